// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encodings and mode constants for the sequential Booth multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth add/sub followed by an arithmetic right shift
//
// Ports:
//   acc, q, q_m1 : current partial-product state {acc,q,q_m1}
//   m            : multiplicand, already extended to W bits
//   acc_n, q_n, q_m1_n : state after the add/sub and the 1-bit arithmetic shift
module booth_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] q,
    input  logic         q_m1,
    input  logic [W-1:0] m,
    output logic [W-1:0] acc_n,
    output logic [W-1:0] q_n,
    output logic         q_m1_n
);

    logic [W-1:0] w_sum;

    // {q[0],q_m1}: 01 ends a run of ones -> add, 10 starts one -> subtract.
    always_comb begin
        w_sum = acc;
        unique case ({q[0], q_m1})
            2'b01:   w_sum = acc + m;
            2'b10:   w_sum = acc - m;
            default: w_sum = acc;
        endcase
    end

    assign acc_n  = {w_sum[W-1], w_sum[W-1:1]};
    assign q_n    = {w_sum[0], q[W-1:1]};
    assign q_m1_n = q[0];

endmodule

// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - sequential radix-2 Booth multiplier, signed or unsigned, WIDTH+1 cycle latency
//
// Ports:
//   clock, clear_n       : clock and synchronous active-low reset
//   in_valid, in_ready   : operand handshake (a, b, is_signed)
//   a, b                 : multiplicand and multiplier, WIDTH bits
//   is_signed            : MODE_SIGNED = two's complement, MODE_UNSIGNED = unsigned
//   out_valid, out_ready : product handshake
//   hi, lo               : upper and lower halves of the 2*WIDTH-bit product
module seq_booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // One extra bit lets unsigned operands be treated as positive signed values.
    localparam int W  = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    state_t          r_state;
    state_t          w_state_n;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_m;
    logic            r_q_m1;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [W-1:0]    w_acc_n;
    logic [W-1:0]    w_q_n;
    logic            w_q_m1_n;
    logic            w_sx;
    logic [W-1:0]    w_a_ext;
    logic [W-1:0]    w_b_ext;
    logic            w_last;

    assign w_sx    = (is_signed == MODE_SIGNED);
    assign w_a_ext = {w_sx & a[WIDTH-1], a};
    assign w_b_ext = {w_sx & b[WIDTH-1], b};
    assign w_last  = (r_cnt == CW'(1));

    booth_step #(
        .W (W)
    ) u_step (
        .acc    (r_acc),
        .q      (r_q),
        .q_m1   (r_q_m1),
        .m      (r_m),
        .acc_n  (w_acc_n),
        .q_n    (w_q_n),
        .q_m1_n (w_q_m1_n)
    );

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_n = RUN;
            RUN:     if (w_last)    w_state_n = DONE;
            DONE:    if (out_ready) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_acc  <= '0;
            r_q    <= '0;
            r_m    <= '0;
            r_q_m1 <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_m    <= w_a_ext;
                        r_q    <= w_b_ext;
                        r_acc  <= '0;
                        r_q_m1 <= 1'b0;
                        r_cnt  <= CW'(W);
                    end
                end
                RUN: begin
                    r_acc  <= w_acc_n;
                    r_q    <= w_q_n;
                    r_q_m1 <= w_q_m1_n;
                    r_cnt  <= r_cnt - CW'(1);
                    // The product is the low 2*WIDTH bits of {acc,q} after the final step:
                    // acc[WIDTH-2:0] and all W bits of q.
                    if (w_last) begin
                        r_hi <= {w_acc_n[WIDTH-2:0], w_q_n[WIDTH]};
                        r_lo <= w_q_n[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
